// File: rtl/bram_pkg.sv
// Shared constants for the block-RAM port controller.
// Geometry of the byte-write RAM and its registered read latency.
package bram_pkg;

  localparam int ADDR_W     = 10;
  localparam int NB_COL     = 4;
  localparam int COL_WIDTH  = 8;
  localparam int DW         = NB_COL * COL_WIDTH;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Synchronous response FIFO with a registered head entry.
// Ports: clka/rstb, push+wdata, pop, rdata (head), count, empty, full.
module bram_rsp_fifo #(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clka,
  input  logic             rstb,
  input  logic             push,
  input  logic [DW-1:0]    wdata,
  input  logic             pop,
  output logic [DW-1:0]    rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bram_port_master.sv
// Request-side controller for one port of a byte-write dual-port BRAM.
// Ports: req_* (valid/ready in), rsp_* (valid/ready out), ram_* pins.
module bram_port_master
  import bram_pkg::*;
#(
  parameter int  ADDR_W     = bram_pkg::ADDR_W,
  parameter int  NB_COL     = bram_pkg::NB_COL,
  parameter int  COL_WIDTH  = bram_pkg::COL_WIDTH,
  parameter int  FIFO_DEPTH = bram_pkg::FIFO_DEPTH,
  localparam int DW         = NB_COL * COL_WIDTH
) (
  input  logic              clka,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [NB_COL-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic [NB_COL-1:0] ram_we,
  output logic              ram_en,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DW-1:0]     ram_dout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [OCC_W-1:0]  occ;
  logic              acc;
  logic              push;

  // Every read in the pipe already owns a FIFO slot, so the
  // FIFO can never overflow once req_ready honours occ.
  always_comb begin
    occ = OCC_W'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(pv_q[i]);
    end
  end

  assign req_ready = ~rstb & (occ < OCC_W'(FIFO_DEPTH));
  assign acc       = req_valid & req_ready;

  assign ram_en    = acc;
  assign ram_addr  = req_addr;
  assign ram_din   = req_wdata;
  assign ram_we    = (acc & req_write) ? req_be : '0;
  assign ram_regce = pv_q[0] & ~rstb;
  assign ram_rst   = rstb;

  assign pv_d = {pv_q[RD_LAT-2:0], acc & ~req_write};
  assign push = pv_q[RD_LAT-1];

  always_ff @(posedge clka) begin
    if (rstb) begin
      pv_q <= '0;
    end else begin
      pv_q <= pv_d;
    end
  end

  bram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clka  (clka),
    .rstb  (rstb),
    .push  (push),
    .wdata (ram_dout),
    .pop   (rsp_ready),
    .rdata (rsp_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_valid = ~fifo_empty;

  a_no_overflow: assert property (
    @(posedge clka) disable iff (rstb) !(push && fifo_full)
  ) else $error("rsp fifo push while full");

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: RAM model, scoreboard, directed
// table, multi-cycle corner sequences and randomized traffic.
module tb_bram_port_master;

  localparam int FD = 4;

  logic        clka;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_we;
  logic        ram_en;
  logic        ram_regce;
  logic        ram_rst;
  logic [31:0] ram_dout;

  bram_port_master dut (
    .clka      (clka),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_en    (ram_en),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Write-first byte-write RAM with 2-cycle registered read.
  logic [31:0] ram [1024];
  logic [31:0] ram_lat;
  logic [31:0] ram_out;
  logic [31:0] ram_w;

  always @(posedge clka) begin
    if (ram_en) begin
      ram_w = ram[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ram_w[b*8 +: 8] = ram_din[b*8 +: 8];
      end
      ram[ram_addr] <= ram_w;
      ram_lat       <= ram_w;
    end
    if (ram_rst) ram_out <= '0;
    else if (ram_regce) ram_out <= ram_lat;
  end
  assign ram_dout = ram_out;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          rsp_seen;
  int          base;
  int          k;
  int          gaps;
  int          nv;
  int          first;
  int          last;
  logic        prev_rd;
  logic [31:0] ref_mem [1024];
  exp_t        q [$];
  vec_t        tbl [7];

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  // Reference: outstanding reads are the credit; a read's data is
  // the memory image at accept time; it is visible 3 cycles later.
  task automatic mon_step();
    logic exp_rdy;
    logic exp_en;
    logic exp_rv;
    cyc++;
    if (rstb) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_regce", ram_regce, 0);
      chk("rst_ram_rst", ram_rst, 1);
      q.delete();
      prev_rd = 1'b0;
    end else begin
      exp_rdy = (q.size() < FD);
      exp_en  = req_valid && exp_rdy;
      chk("req_ready", req_ready, exp_rdy);
      chk("ram_en", ram_en, exp_en);
      chk("ram_we", ram_we, (exp_en && req_write) ? req_be : 4'h0);
      chk("ram_rst", ram_rst, 0);
      chk("ram_regce", ram_regce, prev_rd);
      if (exp_en) begin
        chk("ram_addr", ram_addr, req_addr);
        chk("ram_din", ram_din, req_wdata);
      end
      exp_rv = (q.size() > 0) && (cyc - q[0].c >= 3);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data %h want none", rsp_rdata);
        end else begin
          chk("rsp_rdata", rsp_rdata, q[0].d);
          void'(q.pop_front());
          rsp_seen++;
        end
      end
      prev_rd = exp_en && !req_write;
      if (exp_en) begin
        if (req_write) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
          end
        end else begin
          q.push_back('{ref_mem[req_addr], cyc});
        end
      end
    end
  endtask

  task automatic send(input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clka);
    while (!req_ready && t < 50) begin
      t++;
      @(negedge clka);
    end
    if (t >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: req_ready 0 for 50 cycles, want 1");
    end
    @(posedge clka);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = 4'h0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  // Read accepted in the previous cycle: valid exactly in cycle 3.
  task automatic check_lat(input logic [31:0] exp);
    @(negedge clka);
    chk("lat_c1_valid", rsp_valid, 0);
    @(negedge clka);
    chk("lat_c2_valid", rsp_valid, 0);
    @(negedge clka);
    chk("lat_c3_valid", rsp_valid, 1);
    chk("lat_c3_data", rsp_rdata, exp);
    @(negedge clka);
    chk("no_extra_rsp", rsp_valid, 0);
    @(posedge clka);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    rsp_seen  = 0;
    prev_rd   = 1'b0;
    rstb      = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = 4'hF;
    rsp_ready = 1'b1;

    tbl[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 10'h005, 32'h0, 4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 10'h010, 32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 10'h010, 32'h0000AB00, 4'b0010, 32'h0};
    tbl[4] = '{1'b0, 10'h010, 32'h0, 4'hF, 32'h1122AB44};
    tbl[5] = '{1'b1, 10'h020, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[6] = '{1'b0, 10'h020, 32'h0, 4'h0, 32'hCAFEF00D};

    fork
      forever begin
        @(negedge clka);
        mon_step();
      end
    join_none

    @(negedge clka);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_ram_en", ram_en, 0);
    chk("reset_ram_we", ram_we, 0);
    chk("reset_ram_rst", ram_rst, 1);
    step(2);
    rstb = 1'b0;
    idle();
    @(negedge clka);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_ram_rst_off", ram_rst, 0);
    @(posedge clka);
    #1;

    for (int i = 0; i < 16; i++) begin
      send(1'b1, 10'(i), $urandom, 4'hF);
    end
    idle();
    step(1);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be);
      if (!tbl[i].wr) begin
        idle();
        check_lat(tbl[i].exp);
      end
    end
    idle();
    step(2);

    base      = rsp_seen;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    k         = 0;
    for (int c = 0; c < 10; c++) begin
      req_addr = 10'(k);
      @(negedge clka);
      if (req_ready) k++;
      @(posedge clka);
      #1;
    end
    chk("credit_accepts", k, 4);
    @(negedge clka);
    chk("credit_stall", req_ready, 0);
    chk("credit_hold_valid", rsp_valid, 1);
    @(posedge clka);
    #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      req_addr = 10'(k);
      @(negedge clka);
      if (req_ready) k++;
      @(posedge clka);
      #1;
    end
    idle();
    step(8);
    chk("credit_all_accepted", k, 8);
    chk("credit_rsp_count", rsp_seen - base, 8);

    for (int i = 0; i < 16; i++) begin
      send(1'b1, 10'(10'h3F0 + i), pat(10'(10'h3F0 + i)), 4'hF);
    end
    idle();
    k     = 0;
    gaps  = 0;
    nv    = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 40; c++) begin
      req_valid = (k < 16);
      req_write = 1'b0;
      req_addr  = 10'(10'h3F0 + k);
      @(negedge clka);
      if (req_valid) begin
        if (req_ready) k++;
        else gaps++;
      end
      if (rsp_valid) begin
        chk("stream_data", rsp_rdata, pat(10'(10'h3F0 + nv)));
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clka);
      #1;
    end
    idle();
    chk("stream_ready_gaps", gaps, 0);
    chk("stream_rsp_count", nv, 16);
    chk("stream_consecutive", last - first, 15);

    send(1'b0, 10'h3F0, 32'h0, 4'h0);
    send(1'b0, 10'h3F1, 32'h0, 4'h0);
    send(1'b0, 10'h3F2, 32'h0, 4'h0);
    idle();
    rstb = 1'b1;
    @(negedge clka);
    chk("midrst_ram_rst", ram_rst, 1);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clka);
    #1;
    rstb = 1'b0;
    base = rsp_seen;
    for (int c = 0; c < 10; c++) begin
      @(negedge clka);
      chk("midrst_no_stale", rsp_valid, 0);
    end
    @(posedge clka);
    #1;
    chk("midrst_rsp_count", rsp_seen - base, 0);

    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom % 2);
      req_write = ($urandom % 3) == 0;
      req_addr  = 10'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      rstb      = ($urandom % 128) == 0;
      step(1);
    end
    rstb      = 1'b0;
    rsp_ready = 1'b1;
    idle();
    step(10);
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
